// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and feeder FSM state encodings.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [1:0] {
    FEED_IDLE = 2'd0,
    FEED_WAIT = 2'd1,
    FEED_GAP  = 2'd2
  } feed_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous byte FIFO with registered flags and count.
// Ports:
//   i_clock, i_reset   clock and synchronous active-high reset
//   push, push_data    enqueue request; dropped (and overflow set) when full
//   pop                dequeue request; ignored when empty
//   head_c             combinational view of the entry at the read pointer
//   full, empty        registered flags for the post-edge state
//   count              registered number of stored entries (0..DEPTH)
//   overflow           sticky, set when a push is dropped; cleared by reset
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = UART_DATA_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_c,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_next;
  logic              push_ok;
  logic              pop_ok;

  // Full check uses the pre-edge flag, so a push is dropped even if a pop
  // frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  // Next occupancy.
  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge i_clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, count and flags; pointers wrap naturally at ADDR_W bits.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push && full) begin
        overflow <= 1'b1;
      end
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus issue FSM feeding a UART transmitter one frame at a time.
// Ports:
//   i_clock, i_reset        clock and synchronous active-high reset
//   i_wr_en, i_wr_data      producer push interface
//   o_full, o_empty         FIFO occupancy flags
//   o_count                 bytes stored (0..DEPTH)
//   o_overflow              sticky dropped-push indicator
//   o_TX_Start, o_TX_Byte   start pulse and byte to the transmitter
//   i_TX_Active, i_TX_Done  transmitter busy level and end-of-frame pulse
module uart_tx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_wr_en,
  input  logic [UART_DATA_W-1:0] i_wr_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [ADDR_W:0]        o_count,
  output logic                   o_overflow,
  output logic                   o_TX_Start,
  output logic [UART_DATA_W-1:0] o_TX_Byte,
  input  logic                   i_TX_Active,
  input  logic                   i_TX_Done
);

  feed_state_e            state;
  feed_state_e            state_next;
  logic                   pop_c;
  logic [UART_DATA_W-1:0] head_c;
  logic                   tx_start_next;
  logic [UART_DATA_W-1:0] tx_byte_next;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .push      (i_wr_en),
    .push_data (i_wr_data),
    .pop       (pop_c),
    .head_c    (head_c),
    .full      (o_full),
    .empty     (o_empty),
    .count     (o_count),
    .overflow  (o_overflow)
  );

  // State and transmitter-facing output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= FEED_IDLE;
      o_TX_Start <= 1'b0;
      o_TX_Byte  <= '0;
    end else begin
      state      <= state_next;
      o_TX_Start <= tx_start_next;
      o_TX_Byte  <= tx_byte_next;
    end
  end

  // Issue logic: one byte per frame, waiting for Done plus a one-cycle gap.
  // The Active guard covers a transmitter still busy after a feeder reset.
  always_comb begin
    state_next    = state;
    pop_c         = 1'b0;
    tx_start_next = 1'b0;
    tx_byte_next  = o_TX_Byte;
    case (state)
      FEED_IDLE: begin
        if (!o_empty && !i_TX_Active) begin
          pop_c         = 1'b1;
          tx_byte_next  = head_c;
          tx_start_next = 1'b1;
          state_next    = FEED_WAIT;
        end
      end
      FEED_WAIT: begin
        if (i_TX_Done) begin
          state_next = FEED_GAP;
        end
      end
      FEED_GAP: begin
        state_next = FEED_IDLE;
      end
      default: begin
        state_next = FEED_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo_feeder;

  localparam int DEPTH = 16;
  localparam int FRAME = 80;  // 10 bits x 8 clocks per bit

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_wr_data = 8'h00;
  logic       o_full, o_empty, o_overflow, o_TX_Start;
  logic [4:0] o_count;
  logic [7:0] o_TX_Byte;

  // Behavioural transmitter: starts on the pulse, busy FRAME cycles, Done pulse.
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_stall = 1'b0;
  logic       stab_en = 1'b1;
  int         tx_cnt = 0;
  logic [7:0] tx_hold = 8'h00;
  logic [7:0] rx_q [$];

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  int last_done_cyc = 0;
  int start_cnt = 0;
  int overlap_cnt = 0;
  int pulse_err = 0;
  int stab_err = 0;
  logic prev_start = 1'b0;
  int gap_q [$];

  always #50 i_clock = ~i_clock;

  uart_tx_fifo_feeder #(.DEPTH(16), .ADDR_W(4)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_wr_en     (i_wr_en),
    .i_wr_data   (i_wr_data),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_TX_Start  (o_TX_Start),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (tx_active),
    .i_TX_Done   (tx_done)
  );

  always @(posedge i_clock) begin
    tx_done <= 1'b0;
    if (!tx_active) begin
      if (o_TX_Start === 1'b1) begin
        tx_active <= 1'b1;
        tx_cnt    <= 0;
        tx_hold   <= o_TX_Byte;
      end
    end else if (!tx_stall) begin
      if (tx_cnt == FRAME - 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
        rx_q.push_back(tx_hold);
        if (stab_en && o_TX_Byte !== tx_hold) stab_err <= stab_err + 1;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  // Start-pulse observer: Done-to-Start spacing, pulse width, overlap.
  always @(negedge i_clock) begin
    cyc = cyc + 1;
    if (o_TX_Start === 1'b1) begin
      start_cnt = start_cnt + 1;
      gap_q.push_back(cyc - last_done_cyc);
      if (tx_active) overlap_cnt = overlap_cnt + 1;
      if (prev_start) pulse_err = pulse_err + 1;
    end
    if (tx_done) last_done_cyc = cyc;
    prev_start = (o_TX_Start === 1'b1);
  end

  task automatic wait_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge i_clock);
      k++;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL %s: frames received %0d, required %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic wait_quiet(input string name);
    int k = 0;
    int calm = 0;
    while (calm < 6 && k < 400) begin
      @(negedge i_clock);
      k++;
      if (!tx_active && o_empty && !o_TX_Start) calm++;
      else calm = 0;
    end
    checks++;
    if (calm < 6) begin
      errors++;
      $display("FAIL %s: feeder did not go quiet within 400 cycles", name);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);
    i_reset = 1'b0;
    checks += 6;
    if (o_empty !== 1'b1)    begin errors++; $display("FAIL reset_empty: got %b want 1", o_empty); end
    if (o_full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", o_full); end
    if (o_count !== 5'd0)    begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
    if (o_TX_Start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", o_TX_Start); end
    if (o_TX_Byte !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", o_TX_Byte); end
  endtask

  task automatic test_single();
    int rb = rx_q.size();
    int sb = start_cnt;
    i_wr_en = 1'b1; i_wr_data = 8'hCD;
    @(negedge i_clock);
    i_wr_en = 1'b0;
    checks += 3;
    if (o_empty !== 1'b0)    begin errors++; $display("FAIL single_empty_after_push: got %b want 0", o_empty); end
    if (o_count !== 5'd1)    begin errors++; $display("FAIL single_count_after_push: got %0d want 1", o_count); end
    if (o_TX_Start !== 1'b0) begin errors++; $display("FAIL single_start_early: got %b want 0", o_TX_Start); end
    @(negedge i_clock);
    checks += 4;
    if (o_TX_Start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", o_TX_Start); end
    if (o_TX_Byte !== 8'hCD) begin errors++; $display("FAIL single_byte: got %h want cd", o_TX_Byte); end
    if (o_empty !== 1'b1)    begin errors++; $display("FAIL single_empty_after_pop: got %b want 1", o_empty); end
    if (o_count !== 5'd0)    begin errors++; $display("FAIL single_count_after_pop: got %0d want 0", o_count); end
    @(negedge i_clock);
    checks++;
    if (o_TX_Start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b want 0", o_TX_Start); end
    wait_rx(rb + 1, 200, "single_rx");
    wait_quiet("single_quiet");
    checks += 3;
    if (rx_q.size() > rb && rx_q[rb] !== 8'hCD) begin errors++; $display("FAIL single_rx_data: got %h want cd", rx_q[rb]); end
    if (start_cnt - sb != 1) begin errors++; $display("FAIL single_start_count: got %0d want 1", start_cnt - sb); end
    if (o_TX_Byte !== 8'hCD) begin errors++; $display("FAIL single_byte_hold: got %h want cd", o_TX_Byte); end
  endtask

  task automatic test_burst();
    int rb = rx_q.size();
    int sb = start_cnt;
    int gb = gap_q.size();
    int peak = 0;
    for (int i = 0; i < 5; i++) begin
      i_wr_en = 1'b1; i_wr_data = 8'(i + 1);
      @(negedge i_clock);
      if (int'(o_count) > peak) peak = int'(o_count);
    end
    i_wr_en = 1'b0;
    repeat (3) begin
      @(negedge i_clock);
      if (int'(o_count) > peak) peak = int'(o_count);
    end
    checks++;
    if (peak != 4) begin errors++; $display("FAIL burst_peak_count: got %0d want 4", peak); end
    wait_rx(rb + 5, 600, "burst_rx");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_q.size() <= rb + i || rx_q[rb + i] !== 8'(i + 1)) begin
        errors++; $display("FAIL burst_data[%0d]: got %h want %h", i, (rx_q.size() > rb + i) ? rx_q[rb + i] : 8'hxx, 8'(i + 1));
      end
    end
    wait_quiet("burst_quiet");
    checks++;
    if (start_cnt - sb != 5) begin errors++; $display("FAIL burst_start_count: got %0d want 5", start_cnt - sb); end
    // Done cycle -> GAP -> IDLE -> Start visible: three sampled cycles apart.
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (gap_q.size() <= gb + i || gap_q[gb + i] != 3) begin
        errors++; $display("FAIL burst_done_to_start[%0d]: got %0d want 3", i, (gap_q.size() > gb + i) ? gap_q[gb + i] : -1);
      end
    end
  endtask

  task automatic test_overflow();
    int rb = rx_q.size();
    int sb = start_cnt;
    tx_stall = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      i_wr_en = 1'b1; i_wr_data = 8'(8'h40 + i);
      @(negedge i_clock);
    end
    i_wr_en = 1'b0;
    @(negedge i_clock);
    checks += 3;
    if (o_full !== 1'b1)     begin errors++; $display("FAIL ovf_full: got %b want 1", o_full); end
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
    if (o_count !== 5'd16)   begin errors++; $display("FAIL ovf_count: got %0d want 16", o_count); end
    tx_stall = 1'b0;
    wait_rx(rb + DEPTH + 1, 2000, "ovf_rx");
    for (int i = 0; i < DEPTH + 1; i++) begin
      checks++;
      if (rx_q.size() <= rb + i || rx_q[rb + i] !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL ovf_data[%0d]: got %h want %h", i, (rx_q.size() > rb + i) ? rx_q[rb + i] : 8'hxx, 8'(8'h40 + i));
      end
    end
    wait_quiet("ovf_quiet");
    checks += 2;
    if (start_cnt - sb != DEPTH + 1) begin errors++; $display("FAIL ovf_start_count: got %0d want %0d", start_cnt - sb, DEPTH + 1); end
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      int rb = rx_q.size();
      for (int i = 0; i < 12; i++) begin
        i_wr_en = 1'b1; i_wr_data = 8'(8'h80 + r * 16 + i);
        @(negedge i_clock);
      end
      i_wr_en = 1'b0;
      wait_rx(rb + 12, 1500, "wrap_rx");
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (rx_q.size() <= rb + i || rx_q[rb + i] !== 8'(8'h80 + r * 16 + i)) begin
          errors++; $display("FAIL wrap_data[%0d][%0d]: got %h want %h", r, i, (rx_q.size() > rb + i) ? rx_q[rb + i] : 8'hxx, 8'(8'h80 + r * 16 + i));
        end
      end
      wait_quiet("wrap_quiet");
      checks++;
      if (o_count !== 5'd0) begin errors++; $display("FAIL wrap_count[%0d]: got %0d want 0", r, o_count); end
    end
  endtask

  task automatic test_full_push_pop();
    int rb, sb, k;
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow_cleared: got %b want 0", o_overflow); end
    rb = rx_q.size();
    sb = start_cnt;
    tx_stall = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      i_wr_en = 1'b1; i_wr_data = 8'(8'hC0 + i);
      @(negedge i_clock);
    end
    i_wr_en = 1'b0;
    checks += 3;
    if (o_full !== 1'b1)     begin errors++; $display("FAIL pp_full: got %b want 1", o_full); end
    if (o_count !== 5'd16)   begin errors++; $display("FAIL pp_count_full: got %0d want 16", o_count); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL pp_no_overflow_yet: got %b want 0", o_overflow); end
    tx_stall = 1'b0;
    k = 0;
    while (tx_done !== 1'b1 && k < 200) begin
      @(negedge i_clock);
      k++;
    end
    checks++;
    if (tx_done !== 1'b1) begin errors++; $display("FAIL pp_done_timeout: no Done within 200 cycles"); end
    // GAP then IDLE; push lands on the edge where IDLE pops.
    repeat (2) @(negedge i_clock);
    i_wr_en = 1'b1; i_wr_data = 8'hEE;
    @(negedge i_clock);
    i_wr_en = 1'b0;
    checks += 4;
    if (o_TX_Start !== 1'b1) begin errors++; $display("FAIL pp_pop_same_cycle: start got %b want 1", o_TX_Start); end
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL pp_overflow: got %b want 1", o_overflow); end
    if (o_count !== 5'd15)   begin errors++; $display("FAIL pp_count: got %0d want 15", o_count); end
    if (o_full !== 1'b0)     begin errors++; $display("FAIL pp_full_after: got %b want 0", o_full); end
    wait_rx(rb + DEPTH + 1, 2000, "pp_rx");
    for (int i = 0; i < DEPTH + 1; i++) begin
      checks++;
      if (rx_q.size() <= rb + i || rx_q[rb + i] !== 8'(8'hC0 + i)) begin
        errors++; $display("FAIL pp_data[%0d]: got %h want %h", i, (rx_q.size() > rb + i) ? rx_q[rb + i] : 8'hxx, 8'(8'hC0 + i));
      end
    end
    wait_quiet("pp_quiet");
    checks++;
    if (start_cnt - sb != DEPTH + 1) begin errors++; $display("FAIL pp_start_count: got %0d want %0d", start_cnt - sb, DEPTH + 1); end
  endtask

  task automatic test_reset_mid_frame();
    int rb = rx_q.size();
    int sb = start_cnt;
    int ob = overlap_cnt;
    for (int i = 0; i < 4; i++) begin
      i_wr_en = 1'b1; i_wr_data = 8'(8'hE0 + i);
      @(negedge i_clock);
    end
    i_wr_en = 1'b0;
    repeat (8) @(negedge i_clock);
    checks += 2;
    if (tx_active !== 1'b1) begin errors++; $display("FAIL mid_tx_busy: got %b want 1", tx_active); end
    if (o_count !== 5'd3)   begin errors++; $display("FAIL mid_queued: got %0d want 3", o_count); end
    stab_en = 1'b0;
    i_reset = 1'b1;
    @(negedge i_clock);
    i_reset = 1'b0;
    checks += 6;
    if (o_empty !== 1'b1)    begin errors++; $display("FAIL mid_empty: got %b want 1", o_empty); end
    if (o_count !== 5'd0)    begin errors++; $display("FAIL mid_count: got %0d want 0", o_count); end
    if (o_full !== 1'b0)     begin errors++; $display("FAIL mid_full: got %b want 0", o_full); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b want 0", o_overflow); end
    if (o_TX_Start !== 1'b0) begin errors++; $display("FAIL mid_start: got %b want 0", o_TX_Start); end
    if (o_TX_Byte !== 8'h00) begin errors++; $display("FAIL mid_byte: got %h want 00", o_TX_Byte); end
    i_wr_en = 1'b1; i_wr_data = 8'hA5;
    @(negedge i_clock);
    i_wr_en = 1'b0;
    repeat (5) @(negedge i_clock);
    checks += 3;
    if (tx_active !== 1'b1)  begin errors++; $display("FAIL mid_still_busy: got %b want 1", tx_active); end
    if (o_TX_Start !== 1'b0) begin errors++; $display("FAIL mid_guard_start: got %b want 0", o_TX_Start); end
    if (o_count !== 5'd1)    begin errors++; $display("FAIL mid_guard_count: got %0d want 1", o_count); end
    wait_rx(rb + 2, 400, "mid_rx");
    wait_quiet("mid_quiet");
    stab_en = 1'b1;
    checks += 4;
    if (rx_q.size() > rb && rx_q[rb] !== 8'hE0)         begin errors++; $display("FAIL mid_old_frame: got %h want e0", rx_q[rb]); end
    if (rx_q.size() > rb + 1 && rx_q[rb + 1] !== 8'hA5) begin errors++; $display("FAIL mid_new_frame: got %h want a5", rx_q[rb + 1]); end
    if (overlap_cnt != ob)   begin errors++; $display("FAIL mid_overlap: got %0d overlapping starts want 0", overlap_cnt - ob); end
    if (start_cnt - sb != 2) begin errors++; $display("FAIL mid_start_count: got %0d want 2", start_cnt - sb); end
  endtask

  task automatic test_pulse_integrity();
    checks += 2;
    if (pulse_err != 0) begin errors++; $display("FAIL start_width: got %0d wide pulses want 0", pulse_err); end
    if (stab_err != 0)  begin errors++; $display("FAIL byte_stable: got %0d unstable frames want 0", stab_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_full_push_pop();
    test_reset_mid_frame();
    test_pulse_integrity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
